lr35902_intctl: RTL

LR35902_INTCTL -- requirements
Module: lr35902_intctl

---
 rtl/lr35902_intctl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/lr35902_intctl.sv
// LR35902 interrupt controller: IF/IE registers, source edge detection,
// priority selection and a small dispatch FSM (IDLE -> PEND -> VEC).
// Optional build macro LR35902_INTCTL_SYNC_EN inserts a 2-flop synchronizer
// on irq_src ahead of edge detection; when undefined, irq_src is sampled
// directly.
module lr35902_intctl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs_if,
    input  logic       cs_ie,
    input  logic       wr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [4:0] irq_src,
    output logic       int_req,
    input  logic       int_ack,
    output logic [7:0] vec,
    output logic       vec_valid,
    output logic       wake
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_VEC  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [4:0] r_if;
    logic [4:0] w_if_next;
    logic [7:0] r_ie;
    logic [4:0] r_src_prev;
    logic [7:0] r_vec;
    logic [7:0] w_vec_next;
    logic [4:0] w_src_s;
    logic [4:0] w_rise;
    logic [4:0] w_pending;
    logic [4:0] w_clr_mask;
    logic [2:0] w_idx;
    logic       w_ack_ok;

`ifdef LR35902_INTCTL_SYNC_EN
    logic [4:0] r_sync1;
    logic [4:0] r_sync2;

    // Two-stage synchronizer for asynchronous interrupt sources.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 5'h00;
            r_sync2 <= 5'h00;
        end else begin
            r_sync1 <= irq_src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src_s = r_sync2;
`else
    assign w_src_s = irq_src;
`endif

    // Rising edges relative to the previous sample; history starts at zero
    // so a source already high at reset release still raises its flag.
    assign w_rise    = w_src_s & ~r_src_prev;
    assign w_pending = r_if & r_ie[4:0];
    assign w_ack_ok  = int_ack && (r_state != ST_VEC);
    assign wake      = |w_pending;

    // Priority encoder: lowest set index wins (vblank highest).
    always_comb begin
        w_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    // Acknowledge clears only the selected flag, and only if something was pending.
    always_comb begin
        w_clr_mask = 5'h00;
        if (w_ack_ok && (w_pending != 5'h00)) begin
            w_clr_mask = 5'h01 << w_idx;
        end
    end

    // IF next value: CPU write, then acknowledge clear, then source edges win.
    always_comb begin
        w_if_next = r_if;
        if (wr && cs_if) begin
            w_if_next = din[4:0];
        end
        w_if_next = (w_if_next & ~w_clr_mask) | w_rise;
    end

    // Vector is captured on an accepted acknowledge and held otherwise;
    // a cancelled dispatch (nothing pending) yields 0x00.
    always_comb begin
        w_vec_next = r_vec;
        if (w_ack_ok) begin
            if (w_pending != 5'h00) begin
                w_vec_next = 8'h40 + {2'b00, w_idx, 3'b000};
            end else begin
                w_vec_next = 8'h00;
            end
        end
    end

    // Register state: flags, enables, source history and latched vector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_if       <= 5'h00;
            r_ie       <= 8'h00;
            r_src_prev <= 5'h00;
            r_vec      <= 8'h00;
        end else begin
            r_if       <= w_if_next;
            r_src_prev <= w_src_s;
            r_vec      <= w_vec_next;
            if (wr && cs_ie) begin
                r_ie <= din;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and decoded outputs; VEC always lasts exactly one cycle.
    always_comb begin
        w_state_next = r_state;
        int_req      = 1'b0;
        vec_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ack_ok) begin
                    w_state_next = ST_VEC;
                end else if (w_pending != 5'h00) begin
                    w_state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                int_req = 1'b1;
                if (w_ack_ok) begin
                    w_state_next = ST_VEC;
                end else if (w_pending == 5'h00) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_VEC: begin
                vec_valid = 1'b1;
                if (w_pending != 5'h00) begin
                    w_state_next = ST_PEND;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Register read mux; unused IF bits read as ones.
    always_comb begin
        dout = 8'h00;
        if (cs_if) begin
            dout = {3'b111, r_if};
        end else if (cs_ie) begin
            dout = r_ie;
        end
    end

    assign vec = r_vec;

endmodule
